// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared pipeline-control types: register address, operand
//               select, forwarding source and memory FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    typedef logic [4:0] regaddr_t;

    typedef enum logic [1:0] {
        SEL_REG  = 2'd0,
        SEL_IMM  = 2'd1,
        SEL_PC   = 2'd2,
        SEL_ZERO = 2'd3
    } sel_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_t;

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mstate_t;

    // A load result is not yet available in EX, so it can only come from MEM.
    function automatic fwd_t fwd_pick(input logic use_r, input logic hit_ex,
                                      input logic hit_mem, input logic ex_is_load);
        fwd_t f;
        f = FWD_REG;
        if (use_r && hit_ex && !ex_is_load) begin
            f = FWD_EX;
        end else if (use_r && hit_mem) begin
            f = FWD_MEM;
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational operand forwarding select and load-use detect.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic     id_valid,
    input  sel_t     id_a_sel,
    input  sel_t     id_b_sel,
    input  regaddr_t id_ra_addr,
    input  regaddr_t id_rb_addr,
    input  logic     ex_valid,
    input  regaddr_t ex_rd_addr,
    input  logic     ex_rd_we,
    input  logic     ex_is_load,
    input  logic     mem_valid,
    input  regaddr_t mem_rd_addr,
    input  logic     mem_rd_we,
    output fwd_t     fwd_a,
    output fwd_t     fwd_b,
    output logic     load_use
);

    logic w_use_a;
    logic w_use_b;
    logic w_hit_ex_a;
    logic w_hit_ex_b;
    logic w_hit_mem_a;
    logic w_hit_mem_b;

    // r0 is hardwired zero, so it never creates a dependency.
    assign w_use_a     = (id_a_sel == SEL_REG) && (id_ra_addr != 5'd0);
    assign w_use_b     = (id_b_sel == SEL_REG) && (id_rb_addr != 5'd0);
    assign w_hit_ex_a  = ex_valid  && ex_rd_we  && (ex_rd_addr  == id_ra_addr);
    assign w_hit_ex_b  = ex_valid  && ex_rd_we  && (ex_rd_addr  == id_rb_addr);
    assign w_hit_mem_a = mem_valid && mem_rd_we && (mem_rd_addr == id_ra_addr);
    assign w_hit_mem_b = mem_valid && mem_rd_we && (mem_rd_addr == id_rb_addr);

    assign fwd_a    = fwd_pick(w_use_a, w_hit_ex_a, w_hit_mem_a, ex_is_load);
    assign fwd_b    = fwd_pick(w_use_b, w_hit_ex_b, w_hit_mem_b, ex_is_load);
    assign load_use = id_valid && ex_is_load &&
                      ((w_use_a && w_hit_ex_a) || (w_use_b && w_hit_ex_b));

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Five-stage pipeline control: stage valids, stalls, redirect
//               flush and data-memory handshake FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     if_valid,
    input  sel_t     id_a_sel,
    input  sel_t     id_b_sel,
    input  regaddr_t id_ra_addr,
    input  regaddr_t id_rb_addr,
    input  regaddr_t ex_rd_addr,
    input  logic     ex_rd_we,
    input  logic     ex_is_load,
    input  regaddr_t mem_rd_addr,
    input  logic     mem_rd_we,
    input  logic     mem_access,
    input  logic     ex_redirect,
    input  logic     dmem_ack,
    output logic     dmem_req,
    output logic     id_valid,
    output logic     ex_valid,
    output logic     mem_valid,
    output logic     wb_valid,
    output logic     pc_hold,
    output logic     id_hold,
    output fwd_t     fwd_a,
    output fwd_t     fwd_b
);

    mstate_t r_state;
    mstate_t w_state_nxt;
    logic    r_id_valid, r_ex_valid, r_mem_valid, r_wb_valid;
    logic    w_id_nxt, w_ex_nxt, w_mem_nxt, w_wb_nxt;
    logic    w_load_use;
    logic    w_freeze;
    logic    w_req;
    logic    w_hold;

    hazard_detect u_hazard_detect (
        .id_valid    (r_id_valid),
        .id_a_sel    (id_a_sel),
        .id_b_sel    (id_b_sel),
        .id_ra_addr  (id_ra_addr),
        .id_rb_addr  (id_rb_addr),
        .ex_valid    (r_ex_valid),
        .ex_rd_addr  (ex_rd_addr),
        .ex_rd_we    (ex_rd_we),
        .ex_is_load  (ex_is_load),
        .mem_valid   (r_mem_valid),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_we   (mem_rd_we),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .load_use    (w_load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= M_IDLE;
            r_id_valid  <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_id_valid  <= w_id_nxt;
            r_ex_valid  <= w_ex_nxt;
            r_mem_valid <= w_mem_nxt;
            r_wb_valid  <= w_wb_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_freeze    = 1'b0;
        w_hold      = 1'b0;
        w_id_nxt    = if_valid;
        w_ex_nxt    = r_id_valid;
        w_mem_nxt   = r_ex_valid;
        w_wb_nxt    = r_mem_valid;

        case (r_state)
            M_IDLE: begin
                if (r_mem_valid && mem_access) begin
                    w_req = 1'b1;
                    if (!dmem_ack) begin
                        w_freeze    = 1'b1;
                        w_state_nxt = M_WAIT;
                    end
                end
            end
            M_WAIT: begin
                if (dmem_ack) begin
                    w_state_nxt = M_IDLE;
                end else begin
                    w_freeze = 1'b1;
                end
            end
            default: w_state_nxt = M_IDLE;
        endcase

        // Redirect outranks load-use: the dependent instruction is flushed anyway.
        if (w_freeze) begin
            w_hold    = 1'b1;
            w_id_nxt  = r_id_valid;
            w_ex_nxt  = r_ex_valid;
            w_mem_nxt = r_mem_valid;
            w_wb_nxt  = 1'b0;
        end else if (ex_redirect) begin
            w_id_nxt = 1'b0;
            w_ex_nxt = 1'b0;
        end else if (w_load_use) begin
            w_hold   = 1'b1;
            w_id_nxt = r_id_valid;
            w_ex_nxt = 1'b0;
        end
    end

    assign dmem_req  = w_req;
    assign pc_hold   = w_hold;
    assign id_hold   = w_hold;
    assign id_valid  = r_id_valid;
    assign ex_valid  = r_ex_valid;
    assign mem_valid = r_mem_valid;
    assign wb_valid  = r_wb_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     if_valid;
    sel_t     id_a_sel, id_b_sel;
    regaddr_t id_ra_addr, id_rb_addr, ex_rd_addr, mem_rd_addr;
    logic     ex_rd_we, ex_is_load, mem_rd_we, mem_access, ex_redirect, dmem_ack;
    logic     dmem_req, id_valid, ex_valid, mem_valid, wb_valid, pc_hold, id_hold;
    fwd_t     fwd_a, fwd_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
        .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_access(mem_access),
        .ex_redirect(ex_redirect), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid),
        .wb_valid(wb_valid), .pc_hold(pc_hold), .id_hold(id_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // valids packed as {id,ex,mem,wb}
    task automatic chk_v(input string tag, input logic [3:0] exp);
        chk(tag, {id_valid, ex_valid, mem_valid, wb_valid}, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0;
        id_a_sel = SEL_IMM; id_b_sel = SEL_IMM; id_ra_addr = '0; id_rb_addr = '0;
        ex_rd_addr = '0; ex_rd_we = 1'b0; ex_is_load = 1'b0;
        mem_rd_addr = '0; mem_rd_we = 1'b0; mem_access = 1'b0;
        ex_redirect = 1'b0; dmem_ack = 1'b0;

        // Reset state
        #12;
        chk_v("reset_valids", 4'b0000);
        chk("reset_req", dmem_req, 1'b0);
        chk("reset_hold", pc_hold, 1'b0);

        // First edge after reset is a normal advance; fill the pipe
        rst_n = 1'b1; if_valid = 1'b1;
        tick(); chk_v("fill1", 4'b1000);
        tick(); chk_v("fill2", 4'b1100);
        tick(); chk_v("fill3", 4'b1110);
        tick(); chk_v("fill4", 4'b1111);

        // Forwarding from EX, r0 never forwards
        ex_rd_addr = 5'd5; ex_rd_we = 1'b1; id_a_sel = SEL_REG; id_ra_addr = 5'd5;
        #1 chk("fwd_a_ex", fwd_a, FWD_EX);
        id_ra_addr = 5'd0; ex_rd_addr = 5'd0;
        #1 chk("fwd_a_r0", fwd_a, FWD_REG);
        // MEM forward, EX priority over MEM, non-REG select ignored
        ex_rd_addr = 5'd5; id_ra_addr = 5'd5; mem_rd_addr = 5'd5; mem_rd_we = 1'b1;
        id_b_sel = SEL_REG; id_rb_addr = 5'd7;
        #1 chk("fwd_a_prio", fwd_a, FWD_EX);
        chk("fwd_b_reg", fwd_b, FWD_REG);
        mem_rd_addr = 5'd7;
        #1 chk("fwd_b_mem", fwd_b, FWD_MEM);
        id_b_sel = SEL_PC;
        #1 chk("fwd_b_sel", fwd_b, FWD_REG);
        chk("no_hold_fwd", pc_hold, 1'b0);
        id_a_sel = SEL_IMM; mem_rd_we = 1'b0;

        // Load-use on rb=r3
        ex_is_load = 1'b1; ex_rd_addr = 5'd3; id_b_sel = SEL_REG; id_rb_addr = 5'd3;
        #1 chk("lu_pc_hold", pc_hold, 1'b1);
        chk("lu_id_hold", id_hold, 1'b1);
        chk("lu_fwd_b", fwd_b, FWD_REG);
        tick(); chk_v("lu_bubble", 4'b1011);
        // Load now in MEM
        mem_rd_addr = 5'd3; mem_rd_we = 1'b1; ex_is_load = 1'b0; ex_rd_we = 1'b0;
        #1 chk("lu_release", pc_hold, 1'b0);
        chk("lu_fwd_mem", fwd_b, FWD_MEM);
        tick(); chk_v("lu_after", 4'b1101);
        mem_rd_we = 1'b0; id_b_sel = SEL_IMM;
        tick(); chk_v("pre_mem", 4'b1110);

        // Memory access acknowledged after 3 cycles
        mem_access = 1'b1;
        #1 chk("m0_req", dmem_req, 1'b1);
        chk("m0_hold", pc_hold, 1'b1);
        chk("m0_idhold", id_hold, 1'b1);
        tick(); chk_v("m1_valids", 4'b1110);
        chk("m1_req", dmem_req, 1'b0);
        chk("m1_hold", pc_hold, 1'b1);
        tick(); chk_v("m2_valids", 4'b1110);
        chk("m2_req", dmem_req, 1'b0);
        chk("m2_hold", pc_hold, 1'b1);
        dmem_ack = 1'b1;
        #1 chk("m3_hold", pc_hold, 1'b0);
        chk("m3_req", dmem_req, 1'b0);
        tick(); mem_access = 1'b0; dmem_ack = 1'b0;
        #1 chk_v("m_release", 4'b1111);
        chk("m_idle_req", dmem_req, 1'b0);

        // Same-cycle ack, then a stray ack while idle
        mem_access = 1'b1; dmem_ack = 1'b1;
        #1 chk("fast_req", dmem_req, 1'b1);
        chk("fast_hold", pc_hold, 1'b0);
        tick(); mem_access = 1'b0;
        #1 chk("stray_ack_hold", pc_hold, 1'b0);
        chk("stray_ack_req", dmem_req, 1'b0);
        tick(); dmem_ack = 1'b0;
        chk_v("stray_valids", 4'b1111);

        // Redirect together with load-use: redirect wins, no stall
        ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd3;
        id_b_sel = SEL_REG; id_rb_addr = 5'd3; ex_redirect = 1'b1;
        #1 chk("redir_hold", pc_hold, 1'b0);
        chk("redir_idhold", id_hold, 1'b0);
        tick(); ex_redirect = 1'b0; ex_is_load = 1'b0; ex_rd_we = 1'b0; id_b_sel = SEL_IMM;
        chk_v("redir_flush", 4'b0011);
        tick(); chk_v("redir_refill", 4'b1001);
        tick(); chk_v("refill2", 4'b1100);
        tick(); chk_v("refill3", 4'b1110);

        // Reset during M_WAIT abandons the transaction
        mem_access = 1'b1;
        tick(); chk("wait_req", dmem_req, 1'b0);
        chk("wait_hold", pc_hold, 1'b1);
        #2 rst_n = 1'b0; if_valid = 1'b0;
        #1 chk_v("rst_wait_valids", 4'b0000);
        chk("rst_wait_req", dmem_req, 1'b0);
        chk("rst_wait_hold", pc_hold, 1'b0);
        tick(); rst_n = 1'b1; dmem_ack = 1'b1;
        #1 chk("late_ack_req", dmem_req, 1'b0);
        tick(); dmem_ack = 1'b0; if_valid = 1'b1;
        #1 chk("post_rst_hold", pc_hold, 1'b0);
        chk_v("post_rst_valids", 4'b0000);
        tick(); chk_v("post_rst_adv", 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from the shared types package (regaddr_t 5 b, sel_t 2 b).
REQ-002 The block SHALL use a single clock clk and an asynchronous, active-low reset rst_n, with ports listed as name, direction, width, meaning below.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_valid  in  1  fetch delivers an instruction this cycle.
REQ-006 id_a_sel / id_b_sel  in  2 each  ID operand selects (sel_t); SEL_REG means the register is read.
REQ-007 id_ra_addr / id_rb_addr  in  5 each  ID source register addresses.
REQ-008 ex_rd_addr, ex_rd_we, ex_is_load  in  5,1,1  EX destination, write enable, and load flag.
REQ-009 mem_rd_addr, mem_rd_we  in  5,1  MEM destination and write enable.
REQ-010 mem_access  in  1  MEM-stage instruction needs a data-memory transaction.
REQ-011 ex_redirect  in  1  EX resolved a taken branch or jump.
REQ-012 dmem_ack  in  1  data-memory transaction complete.
REQ-013 dmem_req  out  1  one-cycle data-memory request pulse.
REQ-014 id_valid, ex_valid, mem_valid, wb_valid  out  1 each  registered stage-valid bits.
REQ-015 pc_hold, id_hold  out  1 each  IA and IF/ID registers keep their value.
REQ-016 fwd_a / fwd_b  out  2 each  fwd_t operand source for the ID instruction.

Function
REQ-017 Definitions: use_a = (id_a_sel==SEL_REG) and id_ra_addr!=0; use_b is defined the same way for b.
REQ-018 Definitions: hit_ex(x) = ex_valid & ex_rd_we & ex_rd_addr==x; hit_mem(x) = mem_valid & mem_rd_we & mem_rd_addr==x.
REQ-019 Forwarding SHALL be combinational: fwd_a = FWD_EX if use_a & hit_ex & !ex_is_load, else FWD_MEM if use_a & hit_mem, else FWD_REG; fwd_b SHALL follow the same rule; EX SHALL take priority over MEM.
REQ-020 load_use SHALL be id_valid & ((use_a & hit_ex(ra)) | (use_b & hit_ex(rb))) & ex_is_load.
REQ-021 The memory FSM SHALL have two states, M_IDLE and M_WAIT, encoded as mstate_t.
REQ-022 In M_IDLE with mem_valid & mem_access, dmem_req SHALL be 1 for that cycle; if dmem_ack is also 1, the FSM SHALL stay in M_IDLE, otherwise it SHALL go to M_WAIT.
REQ-023 In M_WAIT, dmem_req SHALL be 0; the FSM SHALL return to M_IDLE on the cycle dmem_ack=1.
REQ-024 dmem_ack SHALL be ignored in M_IDLE when no request is pending.
REQ-025 freeze SHALL be (M_IDLE & mem_valid & mem_access & !dmem_ack) | (M_WAIT & !dmem_ack).
REQ-026 Priority SHALL be freeze, then ex_redirect, then load_use, then normal advance.
REQ-027 On freeze: pc_hold=id_hold=1; id/ex/mem_valid SHALL hold their values; wb_valid SHALL go to 0 next cycle.
REQ-028 On ex_redirect (no freeze): id_valid and ex_valid SHALL go to 0 next cycle, mem_valid<=ex_valid, wb_valid<=mem_valid, pc_hold=0; a redirect during freeze SHALL take effect on the release cycle.
REQ-029 On load_use (no freeze, no redirect): pc_hold=id_hold=1; id_valid SHALL hold; ex_valid SHALL go to 0 (bubble); mem/wb SHALL advance; the stall SHALL last exactly 1 cycle.
REQ-030 On normal advance: id_valid<=if_valid, ex_valid<=id_valid, mem_valid<=ex_valid, wb_valid<=mem_valid, holds=0.

Reset
REQ-031 While rst_n=0, all four valid bits SHALL be 0, the FSM SHALL be in M_IDLE, and dmem_req SHALL be 0, asynchronously; a reset during M_WAIT SHALL abandon the transaction.
REQ-032 The first edge after rst_n rises SHALL behave as a normal advance.

Structure
REQ-033 fwd_t (FWD_REG=0, FWD_EX=1, FWD_MEM=2) and mstate_t SHALL be added to the shared types package.
REQ-034 A sub-module hazard_detect (combinational: fwd_a, fwd_b, load_use) SHALL be used; the FSM and valid registers SHALL stay in pipeline_ctrl.

Verification
REQ-035 Verification SHALL cover: EX writes r5 (not a load), ID reads ra=r5 with SEL_REG -> fwd_a=FWD_EX; with r0 instead -> FWD_REG.
REQ-036 Verification SHALL cover: EX load to r3, ID rb=r3 -> one cycle with pc_hold=id_hold=1 and ex_valid=0 next, then fwd_b=FWD_MEM.
REQ-037 Verification SHALL cover: mem_access with dmem_ack after 3 cycles -> dmem_req high exactly 1 cycle, holds high for 3 cycles, wb_valid=0 during the wait.
REQ-038 Verification SHALL cover: ex_redirect together with load_use -> no stall, and id_valid=ex_valid=0 next cycle.
REQ-039 Verification SHALL cover: rst_n pulled low in M_WAIT -> all valid bits=0, dmem_req=0, and a late dmem_ack is ignored.
